// File: rtl/mem_issue_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_issue_arb_pkg
// Shared types and sizing constants for the memory-issue arbitration slice.
//   MEM_NREQ          : number of memory issue queues sharing the LSU port
//   MEM_MAX_INFLIGHT  : ops granted but not yet completed by the LSU
//   MEM_CNT_W         : width of the in-flight credit counter
//   iq_entry_t        : issue-queue entry handed to the LSU front end
//   mem_arb_src_t     : index of the queue that supplied an op
// ---------------------------------------------------------------------------
package mem_issue_arb_pkg;

   localparam int MEM_NREQ         = 2;
   localparam int MEM_MAX_INFLIGHT = 4;
   localparam int MEM_CNT_W        = 3;

   typedef enum logic [1:0] {
      MEM_OP_LOAD  = 2'd0,
      MEM_OP_STORE = 2'd1,
      MEM_OP_AMO   = 2'd2,
      MEM_OP_FENCE = 2'd3
   } mem_op_e;

   typedef struct packed {
      mem_op_e     op;
      logic [3:0]  rob_idx;
      logic [15:0] addr;
   } iq_entry_t;

   typedef logic [$clog2(MEM_NREQ)-1:0] mem_arb_src_t;

endpackage

// File: rtl/mem_issue_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Starting at i_ptr and walking upward
// modulo N, selects the first asserted bit of i_valid.
//   i_valid : request vector
//   i_ptr   : highest-priority index (must be < N)
//   o_grant : one-hot of the picked request (all zero when none)
//   o_idx   : binary index of the picked request
//   o_any   : at least one request present
// Works for non-power-of-2 N; reusable for other shared ports.
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW-1:0] w_j;
   logic          w_found;

   // Walk the N candidate positions in priority order; the first valid one wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = '0;
      for (int k = 0; k < N; k++) begin
         w_j = IW'((int'(i_ptr) + k) % N);
         if (!w_found && i_valid[w_j]) begin
            w_found     = 1'b1;
            o_grant[w_j] = 1'b1;
            o_idx       = w_j;
         end
      end
   end

   assign o_any = |i_valid;

endmodule

// File: rtl/mem_issue_arb.sv
// ---------------------------------------------------------------------------
// mem_issue_arb
// Shares the single LSU issue port between NREQ memory issue queues using a
// round-robin grant, a one-entry registered output stage with valid/ready
// handshake, and a credit counter bounding ops in flight.
// Ports:
//   i_clk, i_reset       : clock, asynchronous active-low reset
//   i_req_valid/entry    : per-queue head valid and entry
//   o_req_pop            : one-hot combinational dequeue strobe
//   o_lsu_valid/entry/src: held op and the queue it came from
//   i_lsu_ready          : LSU takes the held op this cycle
//   i_lsu_done           : one LSU op completed (pulse)
//   i_flush              : pipeline flush; drops a held, not-yet-taken op
//   o_inflight           : current credit usage
//   o_perf_grant/stall   : performance counters
// Optional feature macro: MEM_ISSUE_ARB_PERF_EN enables the perf counters;
// without it the perf outputs are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module mem_issue_arb
   import mem_issue_arb_pkg::*;
#(
   parameter int NREQ         = MEM_NREQ,
   parameter int MAX_INFLIGHT = MEM_MAX_INFLIGHT,
   parameter int CNT_W        = MEM_CNT_W,
   parameter int SRC_W        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NREQ-1:0]       i_req_valid,
   input  iq_entry_t [NREQ-1:0]  i_req_entry,
   output logic [NREQ-1:0]       o_req_pop,
   output logic                  o_lsu_valid,
   output iq_entry_t             o_lsu_entry,
   output logic [SRC_W-1:0]      o_lsu_src,
   input  logic                  i_lsu_ready,
   input  logic                  i_lsu_done,
   input  logic                  i_flush,
   output logic [CNT_W-1:0]      o_inflight,
   output logic [NREQ-1:0][31:0] o_perf_grant,
   output logic [31:0]           o_perf_stall
);

   logic [SRC_W-1:0] r_ptr;
   logic             r_lsu_valid;
   iq_entry_t        r_lsu_entry;
   logic [SRC_W-1:0] r_lsu_src;
   logic [CNT_W-1:0] r_inflight;

   logic [NREQ-1:0]  w_pick_grant;
   logic [SRC_W-1:0] w_pick_idx;
   logic             w_pick_any;
   logic             w_can_load;
   logic             w_can_credit;
   logic             w_grant;
   logic             w_flush_drop;
   logic [CNT_W-1:0] w_infl_after_done;
   logic [CNT_W:0]   w_infl_sum;
   logic [CNT_W:0]   w_infl_dec;
   logic [CNT_W-1:0] w_infl_next;
   logic [SRC_W-1:0] w_ptr_next;

   rr_pick #(.N(NREQ), .IW(SRC_W)) u_rr_pick (
      .i_valid (i_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   // A completion arriving this cycle frees its credit in time for a new grant.
   // The saturating form only matters for the illegal done-at-zero case.
   assign w_infl_after_done = (i_lsu_done && (r_inflight != '0)) ? r_inflight - CNT_W'(1)
                                                                 : r_inflight;
   assign w_can_load   = !r_lsu_valid || i_lsu_ready;
   assign w_can_credit = int'(w_infl_after_done) < MAX_INFLIGHT;
   // Gating with i_reset keeps queues from popping while the arbiter is held in reset.
   assign w_grant      = i_reset && w_can_load && w_can_credit && w_pick_any && !i_flush;
   assign o_req_pop    = w_grant ? w_pick_grant : '0;

   // A flushed op that never reached the LSU will never report done, so its credit
   // is returned here; an op handed off in the flush cycle still returns done.
   assign w_flush_drop = i_flush && r_lsu_valid && !i_lsu_ready;
   assign w_infl_sum   = {1'b0, r_inflight} + (CNT_W+1)'(w_grant);
   assign w_infl_dec   = (CNT_W+1)'(i_lsu_done) + (CNT_W+1)'(w_flush_drop);
   assign w_infl_next  = (w_infl_sum >= w_infl_dec) ? CNT_W'(w_infl_sum - w_infl_dec) : '0;

   assign w_ptr_next = (int'(w_pick_idx) == NREQ - 1) ? '0 : w_pick_idx + SRC_W'(1);

   // Output stage, round-robin pointer and credit counter.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_ptr       <= '0;
         r_lsu_valid <= 1'b0;
         r_lsu_entry <= '0;
         r_lsu_src   <= '0;
         r_inflight  <= '0;
      end else begin
         r_inflight <= w_infl_next;
         if (w_grant) begin
            r_lsu_valid <= 1'b1;
            r_lsu_entry <= i_req_entry[w_pick_idx];
            r_lsu_src   <= w_pick_idx;
            r_ptr       <= w_ptr_next;
         end else if (i_lsu_ready || i_flush) begin
            r_lsu_valid <= 1'b0;
         end
      end
   end

   assign o_lsu_valid = r_lsu_valid;
   assign o_lsu_entry = r_lsu_entry;
   assign o_lsu_src   = r_lsu_src;
   assign o_inflight  = r_inflight;

   // The LSU must never complete more ops than were granted.
   a_no_done_when_empty: assert property (@(posedge i_clk) disable iff (!i_reset)
      !(i_lsu_done && (r_inflight == '0)));

`ifdef MEM_ISSUE_ARB_PERF_EN
   logic [NREQ-1:0][31:0] r_perf_grant;
   logic [31:0]           r_perf_stall;

   // Free-running wrap-around counters, cleared only by reset.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_perf_grant <= '0;
         r_perf_stall <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (o_req_pop[i]) begin
               r_perf_grant[i] <= r_perf_grant[i] + 32'd1;
            end
         end
         if (w_pick_any && !w_grant) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign o_perf_grant = r_perf_grant;
   assign o_perf_stall = r_perf_stall;
`else
   assign o_perf_grant = '0;
   assign o_perf_stall = '0;
`endif

endmodule
